// File: rtl/sram_port_responder_pkg.sv
// sram_port_responder_pkg
//   Shared definitions for the SRAM port responder and its wait timer:
//   FSM state encodings (4 bits), default bus widths, active-low pin
//   levels and a helper that converts an access length into a timer
//   reload value.
//   No ports (package).
package sram_port_responder_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  // External SRAM control pins are active low.
  localparam logic RAM_ASSERT   = 1'b0;
  localparam logic RAM_DEASSERT = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RD_ACC    = 4'd1,
    ST_RD_LATCH  = 4'd2,
    ST_WR_SETUP  = 4'd3,
    ST_WR_PULSE  = 4'd4,
    ST_WR_HOLD   = 4'd5,
    ST_WR_VERIFY = 4'd6,  // only reachable with SRAM_WRITE_VERIFY_EN
    ST_WR_DONE   = 4'd7   // only reachable with SRAM_WRITE_VERIFY_EN
  } state_t;

  // A timed state lasting n cycles starts with the counter at n-1 and
  // leaves on the cycle the counter reads zero.
  function automatic logic [3:0] wait_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// sram_wait_timer
//   Loadable 4-bit down-counter with a zero flag. While load is high the
//   counter takes load_val; otherwise it counts down and parks at zero
//   (it never wraps).
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   load      in   reload request
//   load_val  in   value taken on load
//   zero      out  counter currently reads zero
module sram_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/sram_port_responder.sv
// sram_port_responder
//   Responder side of the RAM request interface. Takes single-word read
//   or write requests and sequences one external asynchronous SRAM
//   (active-low EN/OE/WE, bidirectional data), returning the read word
//   on data_out and a one-cycle done pulse.
//
//   Request handshake: re/we are level-sampled only while idle (busy=0)
//   and only when en=1; write wins if both are high. A request present
//   on an idle edge is accepted on that edge; requests while busy are
//   ignored, not queued. Completion is the single-cycle done pulse; a
//   requester still holding re/we is re-accepted after one idle cycle.
//
//   Optional feature (macro SRAM_WRITE_VERIFY_EN): each write is read
//   back after the hold cycle; a mismatch sets the sticky verify_err and
//   done moves to the cycle after the read-back. Without the macro the
//   read-back states are unreachable and verify_err is tied low.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   en, re, we        chip enable and read/write request levels
//   addr, data_in     request address and write data
//   data_out          last read word (unchanged by writes)
//   done, busy        completion pulse, non-idle indicator
//   verify_err        sticky write-verify mismatch
//   ram_addr          SRAM address pins (latched at accept)
//   ram_data          SRAM data pins (driven only during write phases)
//   ramEN/ramOE/ramWE SRAM control pins, active low
//   dbg_state         current FSM state for observation
module sram_port_responder
  import sram_port_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2            // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              busy,
  output logic              verify_err,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ramEN,
  output logic              ramOE,
  output logic              ramWE,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t            state;
  logic [DATA_W-1:0] wr_data;
  logic              drive;
  logic              oe_q;
  logic              we_q;
  logic              timer_load;
  logic              timer_zero;

  // The timer is held at its reload value in every untimed state, so it
  // already reads WAIT_CYCLES-1 on the first cycle of any timed state.
  assign timer_load = !(state inside {ST_RD_ACC, ST_WR_PULSE, ST_WR_VERIFY});

  sram_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (WAIT_LOAD),
    .zero     (timer_zero)
  );

`ifdef SRAM_WRITE_VERIFY_EN
  logic verify_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
      ram_addr <= '0;
      wr_data  <= '0;
      drive    <= 1'b0;
      oe_q     <= RAM_DEASSERT;
      we_q     <= RAM_DEASSERT;
`ifdef SRAM_WRITE_VERIFY_EN
      verify_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && we) begin
            ram_addr <= addr;
            wr_data  <= data_in;
            drive    <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_WR_SETUP;
          end else if (en && re) begin
            ram_addr <= addr;
            oe_q     <= RAM_ASSERT;
            busy     <= 1'b1;
            state    <= ST_RD_ACC;
          end
        end

        ST_RD_ACC: begin
          if (timer_zero) begin
            data_out <= ram_data;
            oe_q     <= RAM_DEASSERT;
            done     <= 1'b1;
            state    <= ST_RD_LATCH;
          end
        end

        ST_RD_LATCH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_WR_SETUP: begin
          we_q  <= RAM_ASSERT;
          state <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
          if (timer_zero) begin
            we_q  <= RAM_DEASSERT;
            state <= ST_WR_HOLD;
`ifndef SRAM_WRITE_VERIFY_EN
            done  <= 1'b1;
`endif
          end
        end

`ifdef SRAM_WRITE_VERIFY_EN
        // WE went high on entry to hold, so OE can drop here without
        // ever overlapping WE.
        ST_WR_HOLD: begin
          drive <= 1'b0;
          oe_q  <= RAM_ASSERT;
          state <= ST_WR_VERIFY;
        end

        ST_WR_VERIFY: begin
          if (timer_zero) begin
            oe_q <= RAM_DEASSERT;
            if (ram_data != wr_data) verify_q <= 1'b1;
            done  <= 1'b1;
            state <= ST_WR_DONE;
          end
        end

        ST_WR_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
`else
        ST_WR_HOLD: begin
          drive <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
`endif

        default: begin
          drive <= 1'b0;
          oe_q  <= RAM_DEASSERT;
          we_q  <= RAM_DEASSERT;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  assign verify_err = verify_q;
`else
  assign verify_err = 1'b0;
`endif

  // Idle follows en directly; reset forces the chip deselected.
  assign ramEN     = !rst ? RAM_DEASSERT : (busy ? RAM_ASSERT : ~en);
  assign ramOE     = oe_q;
  assign ramWE     = we_q;
  assign ram_data  = drive ? wr_data : {DATA_W{1'bz}};
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_port_responder.sv
// tb_sram_port_responder
//   Directed bench for sram_port_responder with WAIT_CYCLES=2. A small
//   SRAM model answers reads while EN/OE are low and stores on the rising
//   edge of WE. When the bus should be released the bench parks a fixed
//   pattern on it, so any DUT drive shows up as a changed value.
//   Honours SRAM_WRITE_VERIFY_EN for write latency and verify checks.
module tb_sram_port_responder;

  localparam int W = 2;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam int WR_LAT = 2 * W + 2;
`else
  localparam int WR_LAT = W + 1;
`endif
  localparam int WR_PERIOD = WR_LAT + 2;
  localparam int RD_PERIOD = W + 2;
  localparam logic [15:0] PARK = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, re = 1'b0, we = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        done, busy, verify_err;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ramEN, ramOE, ramWE;
  logic [3:0]  dbg_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sram_port_responder #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .en(en), .re(re), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .done(done), .busy(busy),
    .verify_err(verify_err), .ram_addr(ram_addr), .ram_data(ram_data),
    .ramEN(ramEN), .ramOE(ramOE), .ramWE(ramWE), .dbg_state(dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:63] = '{default: 16'h0000};
  logic        corrupt = 1'b0;
  logic        model_drive, park;
  logic [15:0] model_q;

  assign model_drive = rst && !ramEN && !ramOE && ramWE;
  assign model_q     = mem[ram_addr[5:0]] ^ {15'd0, corrupt};
  assign park        = ramOE && !busy;
  assign ram_data    = model_drive ? model_q : (park ? PARK : 16'hzzzz);

  always @(posedge ramWE) if (rst && !ramEN) mem[ram_addr[5:0]] <= ram_data;

  // ---------------- monitors ----------------
  int overlap_cnt = 0, bus_err = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (!ramOE && !ramWE) overlap_cnt++;
    if (!ramOE && ram_data !== model_q) bus_err++;
    if (park && ram_data !== PARK) bus_err++;
    if (done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  int pass_cnt = 0, total_cnt = 0, fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Counts negedges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
  endtask

  task automatic do_write(input string tag, input logic [17:0] a, input logic [15:0] d,
                          input logic also_re);
    int j, lowc;
    logic stable;
    wait_idle();
    en = 1'b1; we = 1'b1; re = also_re; addr = a; data_in = d;
    @(posedge clk);
    #1 we = 1'b0; re = 1'b0;
    j = 0; lowc = 0; stable = 1'b1;
    while (j < 60) begin
      @(negedge clk);
      if (!ramWE) lowc++;
      if (j <= W + 1 && ram_data !== d) stable = 1'b0;
      if (done) break;
      j++;
    end
    check({tag, "_lat"}, 32'(j), 32'(WR_LAT));
    check({tag, "_we_low"}, 32'(lowc), 32'(W));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [17:0] a, input logic [15:0] exp);
    int j, lowc;
    wait_idle();
    en = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1 re = 1'b0;
    j = 0; lowc = 0;
    while (j < 60) begin
      @(negedge clk);
      if (!ramOE) lowc++;
      if (done) break;
      j++;
    end
    check({tag, "_lat"}, 32'(j), 32'(W));
    check({tag, "_oe_low"}, 32'(lowc), 32'(W));
    check({tag, "_data"}, 32'(data_out), 32'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, dc;
    logic ok;

    // Reset state, with en high to confirm the pin stays deselected.
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_en", 32'(ramEN), 32'd1);
    check("rst_oe_we", {30'd0, ramOE, ramWE}, 32'd3);
    check("rst_bus", 32'(ram_data), 32'(PARK));
    check("rst_outs", {28'd0, done, busy, verify_err, 1'b0}, 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Idle, enabled, no request.
    rst = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ramEN !== 1'b0 || ramOE !== 1'b1 || ramWE !== 1'b1 || done !== 1'b0 ||
          ram_data !== PARK) ok = 1'b0;
    end
    check("idle_pins", 32'(ok), 32'd1);
    en = 1'b0;
    #1 check("idle_en_drop", 32'(ramEN), 32'd1);

    // Requests with en low are ignored.
    we = 1'b1; re = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0) ok = 1'b0;
    end
    check("en_low_ignored", 32'(ok), 32'd1);
    we = 1'b0; re = 1'b0;

    // Basic write then read.
    do_write("wr1", 18'h00010, 16'h1234, 1'b0);
    do_read("rd1", 18'h00010, 16'h1234);

    // Simultaneous re/we: write wins, data_out untouched.
    do_write("wr_both", 18'h3FFFF, 16'hFFFF, 1'b1);
    check("wr_keeps_data_out", 32'(data_out), 32'h1234);
    do_read("rd_both", 18'h3FFFF, 16'hFFFF);

    // A read request arriving while busy is dropped.
    wait_idle();
    dc = done_cnt;
    en = 1'b1; we = 1'b1; addr = 18'h00030; data_in = 16'hBEEF;
    @(posedge clk);
    #1 we = 1'b0; re = 1'b1; addr = 18'h00011;
    repeat (2) @(negedge clk);
    re = 1'b0;
    wait_done(n);
    check("busy_ign_addr", 32'(ram_addr), 32'h30);
    repeat (4) @(negedge clk);
    #1 check("busy_ign_done_cnt", 32'(done_cnt - dc), 32'd1);
    check("busy_ign_data_out", 32'(data_out), 32'hFFFF);

    // Ten back-to-back writes with we held high.
    wait_idle();
    dc = done_cnt;
    ok = 1'b1;
    en = 1'b1; we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr = 18'(5 + i); data_in = 16'(5 + i);
      wait_done(n);
      if (i > 0 && n != WR_PERIOD) ok = 1'b0;
      if (ram_addr !== 18'(5 + i)) ok = 1'b0;
    end
    we = 1'b0;
    check("b2b_wr_period", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    #1 check("b2b_wr_count", 32'(done_cnt - dc), 32'd10);

    // Ten back-to-back reads of the same addresses.
    wait_idle();
    ok = 1'b1;
    re = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr = 18'(5 + i);
      wait_done(n);
      if (i > 0 && n != RD_PERIOD) ok = 1'b0;
      if (data_out !== 16'(5 + i)) ok = 1'b0;
    end
    re = 1'b0;
    check("b2b_rd", 32'(ok), 32'd1);

`ifdef SRAM_WRITE_VERIFY_EN
    check("verify_clean", 32'(verify_err), 32'd0);
    corrupt = 1'b1;
    do_write("wr_bad", 18'h0003E, 16'h00AA, 1'b0);
    corrupt = 1'b0;
    check("verify_set", 32'(verify_err), 32'd1);
    do_write("wr_good", 18'h0003D, 16'h0055, 1'b0);
    check("verify_sticky", 32'(verify_err), 32'd1);
`else
    check("verify_tied", 32'(verify_err), 32'd0);
`endif

    check("oe_we_overlap", 32'(overlap_cnt), 32'd0);
    check("bus_conflicts", 32'(bus_err), 32'd0);

    // Reset during the write pulse.
    wait_idle();
    en = 1'b1; we = 1'b1; addr = 18'h0003C; data_in = 16'h5555;
    @(posedge clk);
    #1 we = 1'b0;
    for (int i = 0; i < 10 && ramWE; i++) @(negedge clk);
    check("mid_wr_we_low", 32'(ramWE), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_pins", {29'd0, ramEN, ramOE, ramWE}, 32'd7);
    check("mid_rst_bus", 32'(ram_data), 32'(PARK));
    check("mid_rst_state", {27'd0, busy, dbg_state}, 32'd0);
    check("mid_rst_regs", {verify_err, 15'd0, data_out}, 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    dc = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("mid_rst_no_done", 32'(done_cnt - dc), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
